hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the fixed LOAD/Branch_EX/Branch_LOAD stall equations. Tracks every in-flight
//  register write in a DEPTH-entry shift scoreboard (entry 0 = EX ... DEPTH-1 = WB). Each entry carries
//  a per-instruction result-latency counter. Sits beside the controller: drives ID stall, ID-stage
//  bypass select (early consumers, e.g. branches) and registered EX-stage bypass select (late consumers).
// PARAMETERS
//  NREG    32                  architectural registers; register 0 is hardwired zero
//  RW      $clog2(NREG)        register-index width
//  DEPTH   3                   tracked stages after ID (EX, MEM, WB)
//  NSRC    2                   source operands per instruction (index 0 = rs, 1 = rt)
//  LW      $clog2(DEPTH+1)     latency/select field width
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           asynchronous active-low reset
//  id_valid      in   1           ID holds a real instruction
//  id_src        in   NSRC*RW     source register indices
//  id_src_used   in   NSRC        source actually read
//  id_early      in   1           operands consumed in ID (branch/jr); 0 = consumed in EX
//  id_rw         in   RW          destination register
//  id_regWrite   in   1           instruction writes id_rw
//  id_lat        in   LW          cycles after entering EX until result is bypassable (ALU=1, load=2)
//  flush_mask    in   DEPTH       bit k invalidates entry k at the next edge
//  stall         out  1           hold IF/ID, insert bubble into EX
//  id_fwd        out  NSRC*LW     comb: 0 = regfile, k = forward from entry k-1 now
//  ex_fwd        out  NSRC*LW     registered: select the EX stage uses next cycle (0 = ID-captured value)
// BEHAVIOUR
//  - Entry = {valid, rw, cnt[LW-1:0]}. Reset: all entries invalid, cnt=0; stall=0, id_fwd=0, ex_fwd=0.
//  - issue = id_valid & ~stall. At each edge, entry k -> k+1 with cnt = (cnt==0 ? 0 : cnt-1);
//    entry DEPTH-1 retires. Entry 0 <= {issue & id_regWrite & (id_rw!=0), id_rw, id_lat}; else a bubble.
//  - Stages after EX never stall; a stall inserts a bubble only at entry 0.
//  - flush_mask[k] clears valid of the entry leaving k (the value written at k+1) the same edge; bit 0
//    also squashes the issuing instruction.
//  - Match for source s: used, index !=0, valid entry with rw==src. The youngest match (lowest k) wins.
//    Older matches are ignored.
//  - Early consumer: cnt==0 -> id_fwd=k+1; cnt!=0 -> hazard.
//  - Late consumer: cnt==0 -> id_fwd=k+1, ex_fwd=0; cnt==1 -> id_fwd=0, ex_fwd=k+2; cnt>1 -> hazard.
//  - No match -> id_fwd=0, ex_fwd=0.
//  - stall = id_valid & OR of hazards over all sources. ex_fwd register loads on issue; loads 0 on stall,
//    flush_mask[0] or !id_valid.
//  - id_lat is clamped to DEPTH-1 (the result must be bypassable by WB); clamp guarded by an assertion.
//  - If the ID fields are stable, a stall lasts at most id_lat cycles of the producer.
//  - Reset asserted mid-operation discards all entries immediately; the first issue after release sees
//    an empty board.
// TESTING
//  1. add r3 (lat1) then late-use add r4,r3 next cycle -> stall=0; following cycle ex_fwd[0]=2 (MEM).
//  2. lw r5 (lat2) then late-use r5 -> stall=1 for 1 cycle; then ex_fwd=3 (WB), id_fwd=0.
//  3. add r6 (lat1) then beq r6 (early) -> stall 1 cycle; then id_fwd[0]=2.
//     lw r6 then beq r6 -> stall 2 cycles, then id_fwd[0]=3.
//  4. Two producers of r7 (entries 0 and 1, both cnt 0) -> id_fwd=1 (youngest).
//     id_rw=0 producer -> never stalls, fwd=0.
//  5. lw r8 issued, flush_mask=3'b001 next edge -> dependent reader sees no match.
//     Stall deasserts; fwd=0.
//  6. rst_n low while lw is in MEM and consumer stalled -> stall, id_fwd, ex_fwd=0 asynchronously.
//     After release, the board is empty.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight register writes (entry 0 = EX ... DEPTH-1 = WB) producing
// the ID stall, the combinational ID bypass select and the registered EX bypass select.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int RW    = $clog2(NREG),
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 id_early,
  input  logic [RW-1:0]        id_rw,
  input  logic                 id_regWrite,
  input  logic [LW-1:0]        id_lat,
  input  logic [DEPTH-1:0]     flush_mask,
  output logic                 stall,
  output logic [NSRC*LW-1:0]   id_fwd,
  output logic [NSRC*LW-1:0]   ex_fwd
);

  logic [DEPTH-1:0]   ent_vld;
  logic [RW-1:0]      ent_rw  [DEPTH];
  logic [LW-1:0]      ent_cnt [DEPTH];
  logic               issue;
  logic               accept;
  logic [LW-1:0]      lat_c;
  logic [NSRC-1:0]    hit;
  logic [LW-1:0]      hit_k   [NSRC];
  logic [LW-1:0]      hit_cnt [NSRC];
  logic [NSRC-1:0]    hazard;
  logic [NSRC*LW-1:0] ex_sel;
  logic [NSRC*LW-1:0] ex_fwd_p1;
  logic               flush_unused;

  function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] c);
    return (c == '0) ? '0 : c - LW'(1);
  endfunction

  // A result must be bypassable by the time it reaches WB.
  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
    return (lat > LW'(DEPTH - 1)) ? LW'(DEPTH - 1) : lat;
  endfunction

  assign flush_unused = flush_mask[DEPTH-1];
  assign issue        = id_valid & ~stall;
  assign accept       = issue & ~flush_mask[0];
  assign stall        = id_valid & (|hazard);
  assign ex_fwd       = ex_fwd_p1;

  always_comb begin
    lat_c = clamp_lat(id_lat);
    assert (lat_c <= LW'(DEPTH - 1));
  end

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    hit = '0;
    for (int s = 0; s < NSRC; s++) begin
      hit_k[s]   = '0;
      hit_cnt[s] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_src_used[s] && (|id_src[s*RW +: RW]) && ent_vld[k] &&
            (ent_rw[k] == id_src[s*RW +: RW])) begin
          hit[s]     = 1'b1;
          hit_k[s]   = LW'(k);
          hit_cnt[s] = ent_cnt[k];
        end
      end
    end
  end

  always_comb begin
    hazard = '0;
    id_fwd = '0;
    ex_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (hit[s]) begin
        if (hit_cnt[s] == '0)
          id_fwd[s*LW +: LW] = hit_k[s] + LW'(1);
        else if (!id_early && hit_cnt[s] == LW'(1))
          ex_sel[s*LW +: LW] = hit_k[s] + LW'(2);
        else
          hazard[s] = 1'b1;
      end
    end
  end

  // Stage boundary ID -> EX, and EX..WB shift of the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld   <= '0;
      ex_fwd_p1 <= '0;
      for (int k = 0; k < DEPTH; k++) ent_cnt[k] <= '0;
    end else begin
      ent_vld[0] <= accept & id_regWrite & (|id_rw);
      ent_cnt[0] <= lat_c;
      for (int k = 1; k < DEPTH; k++) begin
        ent_vld[k] <= ent_vld[k-1] & ~flush_mask[k-1];
        ent_cnt[k] <= sat_dec(ent_cnt[k-1]);
      end
      ex_fwd_p1 <= accept ? ex_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    ent_rw[0] <= id_rw;
    for (int k = 1; k < DEPTH; k++) ent_rw[k] <= ent_rw[k-1];
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: ALU/load latency stalls, early/late bypass selects,
// youngest-match priority, flushes, latency clamp and asynchronous reset.
module tb_hazard_scoreboard;
  localparam int RW = 5, LW = 2, DEPTH = 3, NSRC = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               id_valid = 1'b0;
  logic [NSRC*RW-1:0] id_src = '0;
  logic [NSRC-1:0]    id_src_used = '0;
  logic               id_early = 1'b0;
  logic [RW-1:0]      id_rw = '0;
  logic               id_regWrite = 1'b0;
  logic [LW-1:0]      id_lat = '0;
  logic [DEPTH-1:0]   flush_mask = '0;
  logic               stall;
  logic [NSRC*LW-1:0] id_fwd;
  logic [NSRC*LW-1:0] ex_fwd;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(32), .RW(RW), .DEPTH(DEPTH), .NSRC(NSRC), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_early(id_early), .id_rw(id_rw),
    .id_regWrite(id_regWrite), .id_lat(id_lat), .flush_mask(flush_mask),
    .stall(stall), .id_fwd(id_fwd), .ex_fwd(ex_fwd)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [1:0] used, input logic early, input logic [RW-1:0] rw,
                       input logic wr, input logic [LW-1:0] lat);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_early    = early;
    id_rw       = rw;
    id_regWrite = wr;
    id_lat      = lat;
    #1;
  endtask

  task automatic producer(input logic [RW-1:0] rw, input logic [LW-1:0] lat);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b0, rw, 1'b1, lat);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 2'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset held across two clock edges
    #17;
    chk("reset_stall", 8'(stall), 8'h0);
    chk("reset_id_fwd", 8'(id_fwd), 8'h0);
    chk("reset_ex_fwd", 8'(ex_fwd), 8'h0);
    #1 rst_n = 1'b1;
    tick();

    // add r3 (lat1); add r4,r3 -> no stall, EX takes MEM
    producer(5'd3, 2'd1);
    chk("t1_issue_stall", 8'(stall), 8'h0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd4, 1'b1, 2'd1);
    chk("t1_use_stall", 8'(stall), 8'h0);
    chk("t1_use_id_fwd", 8'(id_fwd), 8'h0);
    tick();
    idle(0);
    chk("t1_ex_fwd_mem", 8'(ex_fwd), 8'h2);

    // lw r5 (lat2); late use on rt -> 1-cycle stall then WB
    idle(3);
    producer(5'd5, 2'd2);
    chk("t2_issue_stall", 8'(stall), 8'h0);
    tick();
    drive(1'b1, 5'd0, 5'd5, 2'b10, 1'b0, 5'd9, 1'b0, 2'd1);
    chk("t2_stall_on", 8'(stall), 8'h1);
    chk("t2_stall_id_fwd", 8'(id_fwd), 8'h0);
    tick();
    chk("t2_stall_off", 8'(stall), 8'h0);
    chk("t2_id_fwd", 8'(id_fwd), 8'h0);
    chk("t2_ex_fwd_bubble", 8'(ex_fwd), 8'h0);
    tick();
    idle(0);
    chk("t2_ex_fwd_wb", 8'(ex_fwd), 8'hC);

    // add r6 (lat1); beq r6 -> 1 stall then MEM
    idle(3);
    producer(5'd6, 2'd1);
    tick();
    drive(1'b1, 5'd6, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 2'd0);
    chk("t3a_stall", 8'(stall), 8'h1);
    tick();
    chk("t3a_stall_off", 8'(stall), 8'h0);
    chk("t3a_id_fwd", 8'(id_fwd), 8'h2);
    tick();

    // lw r6 (lat2); beq r6 -> 2 stalls then WB
    idle(3);
    producer(5'd6, 2'd2);
    tick();
    drive(1'b1, 5'd6, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 2'd0);
    chk("t3b_stall1", 8'(stall), 8'h1);
    tick();
    chk("t3b_stall2", 8'(stall), 8'h1);
    tick();
    chk("t3b_stall_off", 8'(stall), 8'h0);
    chk("t3b_id_fwd", 8'(id_fwd), 8'h3);
    tick();

    // two r7 producers: youngest (entry 0) wins on both sources
    idle(3);
    producer(5'd7, 2'd0);
    tick();
    producer(5'd7, 2'd0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 2'b11, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("t4_stall", 8'(stall), 8'h0);
    chk("t4_id_fwd_youngest", 8'(id_fwd), 8'h5);
    tick();
    idle(0);
    chk("t4_ex_fwd", 8'(ex_fwd), 8'h0);

    // write to r0 never creates a dependency
    idle(3);
    producer(5'd0, 2'd2);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("t4_r0_stall", 8'(stall), 8'h0);
    chk("t4_r0_id_fwd", 8'(id_fwd), 8'h0);

    // lw r8 flushed out of EX while its reader stalls
    idle(3);
    producer(5'd8, 2'd2);
    tick();
    flush_mask = 3'b001;
    drive(1'b1, 5'd8, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("t5_stall_pre_flush", 8'(stall), 8'h1);
    tick();
    flush_mask = 3'b000;
    #1;
    chk("t5_stall_after_flush", 8'(stall), 8'h0);
    chk("t5_id_fwd_after_flush", 8'(id_fwd), 8'h0);
    tick();
    chk("t5_ex_fwd_after_flush", 8'(ex_fwd), 8'h0);

    // lw r12 flushed as it leaves MEM while an early reader stalls
    idle(3);
    producer(5'd12, 2'd2);
    tick();
    drive(1'b1, 5'd12, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 2'd0);
    tick();
    flush_mask = 3'b010;
    #1;
    chk("t5b_stall_mem", 8'(stall), 8'h1);
    tick();
    flush_mask = 3'b000;
    #1;
    chk("t5b_stall_off", 8'(stall), 8'h0);
    chk("t5b_id_fwd", 8'(id_fwd), 8'h0);

    // id_lat=3 behaves as 2
    idle(3);
    producer(5'd10, 2'd3);
    tick();
    drive(1'b1, 5'd10, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("clamp_stall", 8'(stall), 8'h1);
    tick();
    chk("clamp_stall_off", 8'(stall), 8'h0);
    tick();
    idle(0);
    chk("clamp_ex_fwd", 8'(ex_fwd), 8'h3);

    // asynchronous reset with lw r11 in MEM and an early reader stalled
    idle(3);
    producer(5'd11, 2'd2);
    tick();
    drive(1'b1, 5'd11, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 2'd0);
    tick();
    chk("t6_stall_mem", 8'(stall), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 8'(stall), 8'h0);
    chk("t6_rst_id_fwd", 8'(id_fwd), 8'h0);
    chk("t6_rst_ex_fwd", 8'(ex_fwd), 8'h0);
    #3 rst_n = 1'b1;
    #1;
    chk("t6_rel_stall", 8'(stall), 8'h0);
    chk("t6_rel_id_fwd", 8'(id_fwd), 8'h0);
    tick();
    chk("t6_rel_ex_fwd", 8'(ex_fwd), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
